// File: rtl/branch_squash_ctrl_pkg.sv
// rtl/branch_squash_ctrl_pkg.sv - shared ROB index, branch writeback and squash types
package branch_squash_ctrl_pkg;

    localparam int NUM_BRU      = 2;
    localparam int COMMIT_WIDTH = 4;
    localparam int ROB_SIZE     = 64;
    localparam int ROB_IDX_W    = $clog2(ROB_SIZE);
    localparam int BRU_SEL_W    = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t     rob_idx;
        logic        has_mispred;
        logic        branch_taken;
        logic [31:0] target_pc;
        logic [31:0] branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic        dueToBranch;
        logic        branch_taken;
        logic [31:0] arch_pc;
    } squashInfo_t;

    typedef enum logic [1:0] {IDLE, PENDING, SQUASH} squash_state_t;

    // The flipped bit toggles on every ROB wrap, so a mismatch inverts the index order.
    function automatic logic rob_older(robIdx_t a, robIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/branch_squash_ctrl_if.sv
// rtl/branch_squash_ctrl_if.sv - writeback, retire and squash signal bundle
interface branch_squash_ctrl_if;
    import branch_squash_ctrl_pkg::*;

    logic          [NUM_BRU-1:0]      i_wb_vld;
    branchwbInfo_t [NUM_BRU-1:0]      i_wb_info;
    logic          [COMMIT_WIDTH-1:0] i_retire_vld;
    robIdx_t       [COMMIT_WIDTH-1:0] i_retire_robIdx;
    logic                             i_flush;
    logic                             o_block_vld;
    robIdx_t                          o_block_robIdx;
    logic                             o_squash_vld;
    squashInfo_t                      o_squash_info;
    logic          [31:0]             o_mispred_cnt;

    modport master (
        output i_wb_vld, i_wb_info, i_retire_vld, i_retire_robIdx, i_flush,
        input  o_block_vld, o_block_robIdx, o_squash_vld, o_squash_info, o_mispred_cnt
    );

    modport slave (
        input  i_wb_vld, i_wb_info, i_retire_vld, i_retire_robIdx, i_flush,
        output o_block_vld, o_block_robIdx, o_squash_vld, o_squash_info, o_mispred_cnt
    );

endinterface

// File: rtl/branch_squash_ctrl_oldest_mispred_sel.sv
// rtl/branch_squash_ctrl_oldest_mispred_sel.sv - picks the oldest mispredicting writeback lane
module oldest_mispred_sel
    import branch_squash_ctrl_pkg::*;
(
    input  logic                    [NUM_BRU-1:0] cand,
    input  robIdx_t                 [NUM_BRU-1:0] rob_idx,
    output logic                                  sel_vld,
    output logic                  [BRU_SEL_W-1:0] sel_lane
);

    // Strictly-older replacement keeps the lower lane on equal rob_idx.
    always_comb begin
        sel_vld  = 1'b0;
        sel_lane = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (cand[i] && (!sel_vld || rob_older(rob_idx[i], rob_idx[sel_lane]))) begin
                sel_vld  = 1'b1;
                sel_lane = BRU_SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_squash_ctrl.sv
// rtl/branch_squash_ctrl.sv - holds the oldest mispredict and squashes when it retires
module branch_squash_ctrl
    import branch_squash_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    branch_squash_ctrl_if.slave  bus
);

    logic    [NUM_BRU-1:0]   cand;
    robIdx_t [NUM_BRU-1:0]   wb_rob;
    logic                    sel_vld;
    logic    [BRU_SEL_W-1:0] sel_lane;
    logic                    retire_hit;
    logic                    take;

    squash_state_t state;
    robIdx_t       held_rob;
    logic          held_taken;
    logic [31:0]   held_target;
    logic [31:0]   held_npc;
    logic          block_vld;
    logic          squash_vld;
    squashInfo_t   squash_info;
    logic [31:0]   mispred_cnt;

    always_comb begin
        cand   = '0;
        wb_rob = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            cand[i]   = bus.i_wb_vld[i] & bus.i_wb_info[i].has_mispred;
            wb_rob[i] = bus.i_wb_info[i].rob_idx;
        end
    end

    oldest_mispred_sel u_sel (
        .cand     (cand),
        .rob_idx  (wb_rob),
        .sel_vld  (sel_vld),
        .sel_lane (sel_lane)
    );

    always_comb begin
        retire_hit = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (bus.i_retire_vld[k] && (bus.i_retire_robIdx[k] == held_rob))
                retire_hit = 1'b1;
        end
    end

    // A retire match outranks any same-cycle candidate, which is younger anyway.
    always_comb begin
        take = 1'b0;
        if (sel_vld) begin
            if (state == IDLE)
                take = 1'b1;
            else if (state == PENDING && !retire_hit)
                take = rob_older(wb_rob[sel_lane], held_rob);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            held_rob    <= '0;
            held_taken  <= 1'b0;
            held_target <= '0;
            held_npc    <= '0;
            block_vld   <= 1'b0;
            squash_vld  <= 1'b0;
            squash_info <= '0;
            mispred_cnt <= '0;
        end else begin
            squash_vld  <= 1'b0;
            squash_info <= '0;
            if (bus.i_flush) begin
                state       <= IDLE;
                held_rob    <= '0;
                held_taken  <= 1'b0;
                held_target <= '0;
                held_npc    <= '0;
                block_vld   <= 1'b0;
            end else begin
                if (take) begin
                    held_rob    <= bus.i_wb_info[sel_lane].rob_idx;
                    held_taken  <= bus.i_wb_info[sel_lane].branch_taken;
                    held_target <= bus.i_wb_info[sel_lane].target_pc;
                    held_npc    <= bus.i_wb_info[sel_lane].branch_npc;
                    block_vld   <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (take)
                            state <= PENDING;
                    end
                    PENDING: begin
                        if (retire_hit) begin
                            state                     <= SQUASH;
                            block_vld                 <= 1'b0;
                            squash_vld                <= 1'b1;
                            squash_info.dueToBranch   <= 1'b1;
                            squash_info.branch_taken  <= held_taken;
                            squash_info.arch_pc       <= held_taken ? held_target : held_npc;
                            mispred_cnt               <= mispred_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_block_vld    = block_vld;
    assign bus.o_block_robIdx = held_rob;
    assign bus.o_squash_vld   = squash_vld;
    assign bus.o_squash_info  = squash_info;
    assign bus.o_mispred_cnt  = mispred_cnt;

endmodule

// File: tb/tb_branch_squash_ctrl.sv
// tb/tb_branch_squash_ctrl.sv - directed bench with a rule-level reference model
module tb_branch_squash_ctrl;
    import branch_squash_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    branch_squash_ctrl_if bus();

    branch_squash_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: rob positions are plain integers 0..127 (flip bit as bit 6).
    bit          m_block_vld;
    int          m_block_rob;
    bit          m_taken;
    logic [31:0] m_target;
    logic [31:0] m_npc;
    logic [31:0] m_cnt;
    bit          m_sq_vld;
    bit          m_sq_taken;
    logic [31:0] m_sq_pc;

    // a is older than b when b lies less than half the ring ahead of a.
    function automatic bit m_older(input int a, input int b);
        return ((a - b) & 127) >= 64;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.i_wb_vld        = '0;
        bus.i_wb_info       = '0;
        bus.i_retire_vld    = '0;
        bus.i_retire_robIdx = '0;
        bus.i_flush         = 1'b0;
    endtask

    task automatic set_wb(input int p, input int rob, input bit taken,
                          input logic [31:0] tgt, input logic [31:0] npc);
        bus.i_wb_vld[p]                  = 1'b1;
        bus.i_wb_info[p].rob_idx         = robIdx_t'(rob[6:0]);
        bus.i_wb_info[p].has_mispred     = 1'b1;
        bus.i_wb_info[p].branch_taken    = taken;
        bus.i_wb_info[p].target_pc       = tgt;
        bus.i_wb_info[p].branch_npc      = npc;
    endtask

    task automatic set_ret(input int lane, input int rob);
        bus.i_retire_vld[lane]    = 1'b1;
        bus.i_retire_robIdx[lane] = robIdx_t'(rob[6:0]);
    endtask

    task automatic cycle();
        @(negedge clk);
        clear_in();
    endtask

    always @(posedge clk) begin
        bit was_sq;
        bit hit;
        int best;
        int best_rob;
        int r;
        if (rst) begin
            m_block_vld = 0; m_block_rob = 0; m_taken = 0; m_target = '0; m_npc = '0;
            m_cnt = '0; m_sq_vld = 0; m_sq_taken = 0; m_sq_pc = '0;
        end else begin
            was_sq = m_sq_vld;
            m_sq_vld = 0; m_sq_taken = 0; m_sq_pc = '0;
            hit = 0;
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (bus.i_retire_vld[k] && int'(bus.i_retire_robIdx[k]) == m_block_rob) hit = 1;
            if (bus.i_flush) begin
                m_block_vld = 0;
            end else if (was_sq) begin
                m_block_vld = 0;
            end else if (m_block_vld && hit) begin
                m_sq_vld    = 1;
                m_sq_taken  = m_taken;
                m_sq_pc     = m_taken ? m_target : m_npc;
                m_cnt       = m_cnt + 1;
                m_block_vld = 0;
            end else begin
                best = -1; best_rob = 0;
                for (int p = 0; p < NUM_BRU; p++) begin
                    r = int'(bus.i_wb_info[p].rob_idx);
                    if (bus.i_wb_vld[p] && bus.i_wb_info[p].has_mispred &&
                        (best < 0 || m_older(r, best_rob))) begin
                        best = p; best_rob = r;
                    end
                end
                if (best >= 0 && (!m_block_vld || m_older(best_rob, m_block_rob))) begin
                    m_block_vld = 1;
                    m_block_rob = best_rob;
                    m_taken     = bus.i_wb_info[best].branch_taken;
                    m_target    = bus.i_wb_info[best].target_pc;
                    m_npc       = bus.i_wb_info[best].branch_npc;
                end
            end
        end
        #1;
        chk("cmp_block_vld", bus.o_block_vld, m_block_vld);
        if (m_block_vld) chk("cmp_block_rob", bus.o_block_robIdx, m_block_rob);
        chk("cmp_squash_vld", bus.o_squash_vld, m_sq_vld);
        chk("cmp_squash_info", bus.o_squash_info, {m_sq_vld, m_sq_taken, m_sq_pc});
        chk("cmp_cnt", bus.o_mispred_cnt, m_cnt);
    end

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_block_vld", bus.o_block_vld, 0);
        chk("rst_block_rob", bus.o_block_robIdx, 0);
        chk("rst_squash_vld", bus.o_squash_vld, 0);
        chk("rst_squash_info", bus.o_squash_info, 0);
        chk("rst_cnt", bus.o_mispred_cnt, 0);
        rst = 1'b0;

        // single taken mispredict
        set_wb(0, 5, 1, 32'h8000_1000, 32'h8000_0004); cycle();
        chk("t1_block_vld", bus.o_block_vld, 1);
        chk("t1_block_rob", bus.o_block_robIdx, 5);
        cycle(); cycle();
        set_ret(0, 5); cycle();
        chk("t1_squash_vld", bus.o_squash_vld, 1);
        chk("t1_arch_pc", bus.o_squash_info.arch_pc, 32'h8000_1000);
        chk("t1_due", bus.o_squash_info.dueToBranch, 1);
        chk("t1_cnt", bus.o_mispred_cnt, 1);
        chk("t1_unblock", bus.o_block_vld, 0);
        cycle();
        chk("t1_pulse_end", bus.o_squash_vld, 0);

        // not-taken mispredict
        set_wb(1, 9, 0, 32'h8000_9000, 32'h8000_0204); cycle();
        set_ret(2, 9); cycle();
        chk("t2_arch_pc", bus.o_squash_info.arch_pc, 32'h8000_0204);
        chk("t2_taken", bus.o_squash_info.branch_taken, 0);
        chk("t2_cnt", bus.o_mispred_cnt, 2);
        cycle();

        // older replacement across the wrap, younger dropped
        set_wb(0, 66, 1, 32'h8000_2000, 32'h8000_0010); cycle();
        chk("t3_held_1_2", bus.o_block_robIdx, 66);
        set_wb(1, 60, 1, 32'h8000_3C00, 32'h8000_00F4); cycle();
        chk("t3_held_0_60", bus.o_block_robIdx, 60);
        set_wb(0, 70, 1, 32'h8000_7070, 32'h8000_0020); cycle();
        chk("t3_younger_drop", bus.o_block_robIdx, 60);
        set_ret(0, 66); cycle();
        chk("t3_stale_retire", bus.o_squash_vld, 0);
        chk("t3_still_block", bus.o_block_vld, 1);
        set_ret(1, 60); cycle();
        chk("t3_arch_pc", bus.o_squash_info.arch_pc, 32'h8000_3C00);
        chk("t3_cnt", bus.o_mispred_cnt, 3);
        cycle();

        // simultaneous ports, then equal rob_idx tie
        set_wb(0, 10, 1, 32'h8000_A000, 32'h8000_0030);
        set_wb(1, 7, 1, 32'h8000_7000, 32'h8000_0040); cycle();
        chk("t4_oldest", bus.o_block_robIdx, 7);
        set_ret(3, 7); cycle();
        chk("t4_squash", bus.o_squash_vld, 1);
        chk("t4_arch_pc", bus.o_squash_info.arch_pc, 32'h8000_7000);
        cycle();
        set_wb(0, 12, 1, 32'h8000_C000, 32'h8000_0050);
        set_wb(1, 12, 1, 32'h8000_D000, 32'h8000_0060); cycle();
        set_ret(0, 12); cycle();
        chk("t4_tie_lane0", bus.o_squash_info.arch_pc, 32'h8000_C000);
        chk("t4_cnt", bus.o_mispred_cnt, 5);
        cycle();

        // flush beats retire match; spurious retire in IDLE
        set_wb(0, 4, 1, 32'h8000_4000, 32'h8000_0070); cycle();
        bus.i_flush = 1'b1; set_ret(0, 4); cycle();
        chk("t5_no_squash", bus.o_squash_vld, 0);
        chk("t5_unblock", bus.o_block_vld, 0);
        chk("t5_cnt", bus.o_mispred_cnt, 5);
        set_ret(0, 4); cycle();
        chk("t5_idle_retire", bus.o_squash_vld, 0);

        // retire/wb collision, wb during SQUASH ignored
        set_wb(0, 3, 1, 32'h8000_3000, 32'h8000_0080); cycle();
        set_ret(1, 3); set_wb(0, 2, 1, 32'h8000_2222, 32'h8000_0090); cycle();
        chk("t6_arch_pc", bus.o_squash_info.arch_pc, 32'h8000_3000);
        chk("t6_cnt", bus.o_mispred_cnt, 6);
        set_wb(1, 20, 1, 32'h8000_2020, 32'h8000_00A0); cycle();
        chk("t6_dropped", bus.o_block_vld, 0);

        // flush during SQUASH keeps the pulse
        set_wb(0, 30, 1, 32'h8000_3030, 32'h8000_00B0); cycle();
        set_ret(0, 30); cycle();
        chk("t7_pulse", bus.o_squash_vld, 1);
        chk("t7_cnt", bus.o_mispred_cnt, 7);
        bus.i_flush = 1'b1; cycle();
        chk("t7_after", bus.o_squash_vld, 0);

        // reset mid-PENDING
        set_wb(0, 8, 1, 32'h8000_8000, 32'h8000_00C0); cycle();
        chk("t8_pending", bus.o_block_vld, 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("t8_rst_block", bus.o_block_vld, 0);
        chk("t8_rst_cnt", bus.o_mispred_cnt, 0);
        set_ret(0, 8); cycle();
        chk("t8_lost", bus.o_squash_vld, 0);
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
